// File: rtl/mul8_arbiter.sv
// mul8_arbiter
// ------------
// Shares a single 8x8 unsigned combinational multiplier among four
// requesters. A round-robin arbiter picks one requester while idle and
// captures its operands. The product is registered one cycle later and
// held as a response until the consumer accepts it. Completed handshakes
// are counted in a saturating 16-bit counter.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   req_valid  per-requester request flags (bit i = requester i)
//   req_a      operand A, requester i in bits [8i+7:8i]
//   req_b      operand B, requester i in bits [8i+7:8i]
//   req_ready  one-hot grant, set only in IDLE for a valid requester
//   rsp_valid  result available (high exactly in DONE)
//   rsp_y      registered 16-bit product
//   rsp_id     index of the requester owning rsp_y
//   rsp_ready  consumer accepts the result (ignored outside DONE)
//   ops_cnt    saturating count of completed responses

module mul8_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [3:0]  req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_y,
    output logic [1:0]  rsp_id,
    input  logic        rsp_ready,
    output logic [15:0] ops_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  opA_q, opA_d;
    logic [7:0]  opB_q, opB_d;
    logic [1:0]  id_q, id_d;
    logic [15:0] rspY_q, rspY_d;
    logic [1:0]  rspId_q, rspId_d;
    logic [15:0] opsCnt_q, opsCnt_d;

    logic [7:0]  rotDouble;
    logic [3:0]  rotValid;
    logic [1:0]  grantOffset;
    logic [1:0]  grantIdx;
    logic        anyValid;
    logic        grant;
    logic [15:0] product;

    // Round-robin search: rotate the request vector so that the requester
    // at ptr sits in bit 0, take the lowest set bit, then add ptr back to
    // recover the absolute index. Duplicating the vector makes the rotate
    // a plain shift.
    always_comb begin
        rotDouble   = {req_valid, req_valid} >> ptr_q;
        rotValid    = rotDouble[3:0];
        grantOffset = 2'd0;
        casez (rotValid)
            4'b???1: grantOffset = 2'd0;
            4'b??10: grantOffset = 2'd1;
            4'b?100: grantOffset = 2'd2;
            4'b1000: grantOffset = 2'd3;
            default: grantOffset = 2'd0;
        endcase
        grantIdx = ptr_q + grantOffset;
        anyValid = |req_valid;
    end

    // A grant is only offered while idle and out of reset, so nothing can
    // be accepted on a cycle that reset is about to discard.
    always_comb begin
        grant     = (state_q == IDLE) && !rst && anyValid;
        req_ready = grant ? (4'b0001 << grantIdx) : 4'b0000;
    end

    // The single shared multiplier works on the captured operands only, so
    // later activity on req_a/req_b cannot disturb an operation in flight.
    always_comb begin
        product = 16'(opA_q) * 16'(opB_q);
    end

    // Next-state and datapath update. Everything holds by default; each
    // state only touches what it owns. The counter saturates at all ones.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        id_d     = id_q;
        rspY_d   = rspY_q;
        rspId_d  = rspId_q;
        opsCnt_d = opsCnt_q;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = MUL;
                    ptr_d   = grantIdx + 2'd1;
                    opA_d   = req_a[{grantIdx, 3'b000} +: 8];
                    opB_d   = req_b[{grantIdx, 3'b000} +: 8];
                    id_d    = grantIdx;
                end
            end
            MUL: begin
                rspY_d  = product;
                rspId_d = id_q;
                state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    if (opsCnt_q != 16'hFFFF) begin
                        opsCnt_d = opsCnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset wins over everything and abandons any
    // operation in flight without producing a response or a count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            opA_q    <= 8'd0;
            opB_q    <= 8'd0;
            id_q     <= 2'd0;
            rspY_q   <= 16'd0;
            rspId_q  <= 2'd0;
            opsCnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            id_q     <= id_d;
            rspY_q   <= rspY_d;
            rspId_q  <= rspId_d;
            opsCnt_q <= opsCnt_d;
        end
    end

    // Response outputs come straight from registers.
    always_comb begin
        rsp_valid = (state_q == DONE);
        rsp_y     = rspY_q;
        rsp_id    = rspId_q;
        ops_cnt   = opsCnt_q;
    end

endmodule

// File: tb/tb_mul8_arbiter.sv
// tb_mul8_arbiter
// ---------------
// Directed and randomized bench for mul8_arbiter. A small reference model
// (pointer, counter, expected product) predicts each grant and response.

module tb_mul8_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_y;
    logic [1:0]  rsp_id;
    logic        rsp_ready;
    logic [15:0] ops_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int mdlPtr = 0;
    int mdlCnt = 0;

    mul8_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .ops_cnt   (ops_cnt)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and on mismatch report tag/observed/expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    // Round-robin winner: first set bit searching ptr, ptr+1, ... mod 4.
    function automatic int modelWinner(input logic [3:0] valid);
        for (int k = 0; k < 4; k++) begin
            if (valid[(mdlPtr + k) % 4]) return (mdlPtr + k) % 4;
        end
        return -1;
    endfunction

    // Synchronous reset for a few cycles; leaves time at posedge+1.
    task automatic applyReset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        mdlPtr = 0;
        mdlCnt = 0;
    endtask

    // One request/response transaction, starting at posedge+1 of an idle
    // cycle. stall = number of DONE cycles with rsp_ready low. scramble
    // changes the operand buses right after the grant. winner returns the
    // granted index or -1 if nothing was granted.
    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] a,
                                 input logic [31:0] b, input int stall,
                                 input bit scramble, output int winner);
        int   w;
        int   expY;
        int   expId;
        logic [3:0] expGrant;
        int   cntBefore;

        req_valid = valid;
        req_a     = a;
        req_b     = b;
        rsp_ready = 1'b1;
        #1;
        w = modelWinner(valid);
        expGrant = (w < 0) ? 4'b0000 : (4'b0001 << w);
        checkOutput("grant", 32'(req_ready), 32'(expGrant));
        winner = w;
        cntBefore = mdlCnt;
        if (w < 0) begin
            @(posedge clk); #1;
            checkOutput("noGrantValid", 32'(rsp_valid), 32'd0);
            checkOutput("noGrantCnt", 32'(ops_cnt), 32'(mdlCnt));
            return;
        end
        expY   = int'(a[8*w +: 8]) * int'(b[8*w +: 8]);
        expId  = w;
        mdlPtr = (w + 1) % 4;

        // MUL cycle: rsp_ready is high here and must be ignored.
        @(posedge clk); #1;
        if (scramble) begin
            req_a = $urandom;
            req_b = $urandom;
        end
        rsp_ready = (stall == 0);
        #1;
        checkOutput("mulValid", 32'(rsp_valid), 32'd0);
        checkOutput("mulReady", 32'(req_ready), 32'd0);
        checkOutput("mulCnt", 32'(ops_cnt), 32'(cntBefore));

        // DONE cycle: result visible two cycles after the grant.
        @(posedge clk); #1;
        checkOutput("doneValid", 32'(rsp_valid), 32'd1);
        checkOutput("doneY", 32'(rsp_y), 32'(expY));
        checkOutput("doneId", 32'(rsp_id), 32'(expId));
        checkOutput("doneReady", 32'(req_ready), 32'd0);

        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            checkOutput("stallValid", 32'(rsp_valid), 32'd1);
            checkOutput("stallY", 32'(rsp_y), 32'(expY));
            checkOutput("stallId", 32'(rsp_id), 32'(expId));
            checkOutput("stallReady", 32'(req_ready), 32'd0);
            checkOutput("stallCnt", 32'(ops_cnt), 32'(cntBefore));
            if (s == stall - 1) rsp_ready = 1'b1;
        end

        // Handshake edge: back in IDLE, counter advanced (saturating).
        @(posedge clk); #1;
        mdlCnt = (mdlCnt >= 16'hFFFF) ? 16'hFFFF : mdlCnt + 1;
        checkOutput("idleValid", 32'(rsp_valid), 32'd0);
        checkOutput("opsCnt", 32'(ops_cnt), 32'(mdlCnt));
        req_valid = 4'b0000;
    endtask

    initial begin : main
        int w;
        int rrOrder [5] = '{0, 1, 2, 3, 0};

        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = 32'd0;
        req_b     = 32'd0;
        rsp_ready = 1'b0;

        // Reset state, with requests present to show reset blocks grants.
        applyReset(3);
        rst = 1'b1;
        #1;
        checkOutput("rstReady", 32'(req_ready), 32'd0);
        checkOutput("rstValid", 32'(rsp_valid), 32'd0);
        checkOutput("rstY", 32'(rsp_y), 32'd0);
        checkOutput("rstId", 32'(rsp_id), 32'd0);
        checkOutput("rstCnt", 32'(ops_cnt), 32'd0);
        req_valid = 4'b0000;
        applyReset(1);

        // Reset while in MUL abandons the operation.
        req_valid = 4'b0100;
        req_a = 32'h0011_2233;
        req_b = 32'h0044_5566;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mdlPtr = 0;
        #1;
        checkOutput("midRstValid", 32'(rsp_valid), 32'd0);
        checkOutput("midRstPtr", 32'(dut.ptr_q), 32'd0);
        checkOutput("midRstCnt", 32'(ops_cnt), 32'd0);
        @(posedge clk); #1;
        checkOutput("midRstStillIdle", 32'(rsp_valid), 32'd0);

        // Single request: 12*13 from requester 1.
        applyStimulus(4'b0010, {16'd0, 8'd12, 8'd0}, {16'd0, 8'd13, 8'd0}, 0, 1'b0, w);
        checkOutput("singleWinner", 32'(w), 32'd1);

        // Round-robin with all four requesting from ptr=0.
        applyReset(2);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, $urandom, $urandom, 0, 1'b0, w);
            checkOutput("rrOrder", 32'(w), 32'(rrOrder[i]));
        end

        // Backpressure: 255*255 from requester 3 stalled for 5 cycles.
        applyStimulus(4'b1000, 32'hFF00_0000, 32'hFF00_0000, 5, 1'b0, w);

        // Operand isolation with scrambled buses, and a zero operand.
        applyStimulus(4'b0001, 32'h0000_00C8, 32'h0000_0000, 0, 1'b1, w);
        applyStimulus(4'b0100, 32'h0037_0000, 32'h0091_0000, 1, 1'b1, w);

        // No request: nothing granted, nothing queued.
        applyStimulus(4'b0000, 32'd0, 32'd0, 0, 1'b0, w);

        // Randomized traffic.
        for (int i = 0; i < 25; i++) begin
            applyStimulus(4'($urandom), $urandom, $urandom,
                          int'($urandom_range(0, 2)), 1'($urandom), w);
        end

        // Counter saturation from 16'hFFFE.
        force dut.opsCnt_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.opsCnt_q;
        mdlCnt = 16'hFFFE;
        #1;
        checkOutput("satPreset", 32'(ops_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0110, $urandom, $urandom, 0, 1'b0, w);
        end
        checkOutput("satHold", 32'(ops_cnt), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the bench always terminates.
    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
